// File: rtl/microsequencer.sv
// microsequencer
//   Next-state logic and state register for the microprogrammed MIPS control
//   unit. Each clock it selects the next microinstruction address from the
//   control word's next-state fields, the opcode dispatch state, or the
//   datapath conditions. It supports dispatch, jump, increment, conditional
//   branch, conditional wait with timeout trap, and a single-level micro
//   call/return.
//
// Ports
//   clk           : rising-edge clock
//   reset         : asynchronous, active-low reset
//   ns_sel        : next-state select field from the control word
//   cond_sel      : condition select (00 moc, 01 zero, 10 cond_in, 11 const 1)
//   cond_inv      : inverts the selected condition
//   cr_state      : target-state field from the control word
//   enc_state     : dispatch state from the opcode encoder
//   moc           : memory operation complete
//   zero          : ALU zero flag
//   cond_in       : branch condition-tester output
//   currentState  : registered state address driven to the microstore
//   ret_state     : micro-return register (visible for debug)
//   illegal_pulse : one-cycle pulse on entry to FETCH after an illegal next state
//   timeout_pulse : one-cycle pulse on entry to TRAP after a wait timeout
module microsequencer #(
  parameter int STATE_W     = 7,
  parameter int MAX_STATE   = 38,
  parameter int FETCH_STATE = 0,
  parameter int TRAP_STATE  = 0,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic [STATE_W-1:0] cr_state,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  input  logic               zero,
  input  logic               cond_in,
  output logic [STATE_W-1:0] currentState,
  output logic [STATE_W-1:0] ret_state,
  output logic               illegal_pulse,
  output logic               timeout_pulse
);

  localparam logic [STATE_W-1:0] MAX_S   = STATE_W'(MAX_STATE);
  localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] TRAP_S  = STATE_W'(TRAP_STATE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] NS_DISPATCH = 3'b000;
  localparam logic [2:0] NS_FETCH    = 3'b001;
  localparam logic [2:0] NS_JUMP     = 3'b010;
  localparam logic [2:0] NS_INC      = 3'b011;
  localparam logic [2:0] NS_BRANCH   = 3'b100;
  localparam logic [2:0] NS_WAIT     = 3'b101;
  localparam logic [2:0] NS_CALL     = 3'b110;
  localparam logic [2:0] NS_RETURN   = 3'b111;

  logic [CNT_W-1:0]   wait_cnt;
  logic               sel_cond;
  logic               c;
  logic [STATE_W-1:0] inc;
  logic [STATE_W-1:0] nxt;
  logic               waiting;
  logic               timeout_hit;
  logic               illegal;

  // Condition mux, increment and next-state candidate. The wait encoding
  // holds on currentState, so a held wait is always legal; only the trap
  // check can redirect it.
  always_comb begin
    sel_cond = 1'b1;
    case (cond_sel)
      2'b00:   sel_cond = moc;
      2'b01:   sel_cond = zero;
      2'b10:   sel_cond = cond_in;
      default: sel_cond = 1'b1;
    endcase
    c   = sel_cond ^ cond_inv;
    inc = currentState + STATE_W'(1);

    nxt = FETCH_S;
    case (ns_sel)
      NS_DISPATCH: nxt = enc_state;
      NS_FETCH:    nxt = FETCH_S;
      NS_JUMP:     nxt = cr_state;
      NS_INC:      nxt = inc;
      NS_BRANCH:   nxt = c ? cr_state : inc;
      NS_WAIT:     nxt = c ? cr_state : currentState;
      NS_CALL:     nxt = cr_state;
      NS_RETURN:   nxt = ret_state;
      default:     nxt = FETCH_S;
    endcase

    waiting     = (ns_sel == NS_WAIT) && !c;
    timeout_hit = waiting && (wait_cnt == CNT_LAST);
    illegal     = (nxt > MAX_S);
  end

  // State, return register, wait counter and event pulses. Timeout wins over
  // the illegal check; an illegal next state suppresses the return-address
  // capture so a bad call leaves ret_state intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      currentState  <= FETCH_S;
      ret_state     <= '0;
      wait_cnt      <= '0;
      illegal_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      illegal_pulse <= !timeout_hit && illegal;
      if (timeout_hit) begin
        currentState <= TRAP_S;
        wait_cnt     <= '0;
      end else begin
        wait_cnt <= waiting ? wait_cnt + CNT_W'(1) : '0;
        if (illegal) begin
          currentState <= FETCH_S;
        end else begin
          currentState <= nxt;
          if (ns_sel == NS_CALL) begin
            ret_state <= inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer
//   Directed-vector bench for the microsequencer. Each vector drives the
//   control fields and conditions, and pushes the hand-computed state
//   expected after the next rising edge into a scoreboard queue; a monitor
//   pops one entry per clock and compares it against the DUT outputs.
module tb_microsequencer;

  logic       clk;
  logic       reset;
  logic [2:0] ns_sel;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [6:0] cr_state;
  logic [6:0] enc_state;
  logic       moc;
  logic       zero;
  logic       cond_in;
  logic [6:0] currentState;
  logic [6:0] ret_state;
  logic       illegal_pulse;
  logic       timeout_pulse;

  typedef struct {
    logic [6:0] state;
    logic [6:0] ret;
    logic       ill;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   vec_count  = 0;
  int   fail_count = 0;

  microsequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ns_sel       (ns_sel),
    .cond_sel     (cond_sel),
    .cond_inv     (cond_inv),
    .cr_state     (cr_state),
    .enc_state    (enc_state),
    .moc          (moc),
    .zero         (zero),
    .cond_in      (cond_in),
    .currentState (currentState),
    .ret_state    (ret_state),
    .illegal_pulse(illegal_pulse),
    .timeout_pulse(timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input exp_t e);
    vec_count++;
    if (currentState !== e.state || ret_state !== e.ret ||
        illegal_pulse !== e.ill || timeout_pulse !== e.tmo) begin
      fail_count++;
      $display("[TB] FAIL %s: got state=%0d ret=%0d ill=%b tmo=%b, expected state=%0d ret=%0d ill=%b tmo=%b",
               e.name, currentState, ret_state, illegal_pulse, timeout_pulse,
               e.state, e.ret, e.ill, e.tmo);
    end
  endtask

  // Monitor: the DUT presents a new registered output every clock.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  task automatic setCtrl(input logic [2:0] ns, input logic [1:0] cs,
                         input logic inv, input logic [6:0] cr);
    ns_sel   = ns;
    cond_sel = cs;
    cond_inv = inv;
    cr_state = cr;
  endtask

  // Called at a falling edge: inputs are already driven, the expectation for
  // the coming rising edge is queued, then we move to the next falling edge.
  task automatic applyStimulus(input logic [6:0] st, input logic [6:0] rt,
                               input logic ill, input logic tmo, input string name);
    exp_t e;
    e.state = st;
    e.ret   = rt;
    e.ill   = ill;
    e.tmo   = tmo;
    e.name  = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t r;
    reset = 1'b0;
    setCtrl(3'b011, 2'b00, 1'b0, 7'd0);
    enc_state = 7'd0;
    moc = 1'b0;
    zero = 1'b0;
    cond_in = 1'b0;
    repeat (2) @(negedge clk);
    r.state = 7'd0; r.ret = 7'd0; r.ill = 1'b0; r.tmo = 1'b0; r.name = "reset_state";
    checkOutput(r);

    // Release reset and increment.
    reset = 1'b1;
    applyStimulus(7'd1, 7'd0, 1'b0, 1'b0, "inc1");
    applyStimulus(7'd2, 7'd0, 1'b0, 1'b0, "inc2");
    applyStimulus(7'd3, 7'd0, 1'b0, 1'b0, "inc3");

    // Asynchronous reset mid-sequence, checked before any clock edge.
    reset = 1'b0;
    #1;
    r.name = "async_reset";
    checkOutput(r);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(7'd1, 7'd0, 1'b0, 1'b0, "inc_after_reset");
    setCtrl(3'b111, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd0, 7'd0, 1'b0, 1'b0, "return_no_call");

    // Dispatch and conditional branch.
    setCtrl(3'b000, 2'b00, 1'b0, 7'd0);
    enc_state = 7'd12;
    applyStimulus(7'd12, 7'd0, 1'b0, 1'b0, "dispatch");
    setCtrl(3'b100, 2'b01, 1'b0, 7'd20);
    zero = 1'b1;
    applyStimulus(7'd20, 7'd0, 1'b0, 1'b0, "branch_taken");
    zero = 1'b0;
    applyStimulus(7'd21, 7'd0, 1'b0, 1'b0, "branch_not_taken");
    cond_inv = 1'b1;
    applyStimulus(7'd20, 7'd0, 1'b0, 1'b0, "branch_inverted");

    // Wait that succeeds after 5 held cycles.
    setCtrl(3'b101, 2'b00, 1'b0, 7'd9);
    moc = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(7'd20, 7'd0, 1'b0, 1'b0, "wait_hold");
    moc = 1'b1;
    applyStimulus(7'd9, 7'd0, 1'b0, 1'b0, "wait_exit");

    // Wait timeout: 14 holds, trap on the 15th, pulse lasts one cycle.
    moc = 1'b0;
    for (int i = 0; i < 14; i++) applyStimulus(7'd9, 7'd0, 1'b0, 1'b0, "timeout_hold");
    applyStimulus(7'd0, 7'd0, 1'b0, 1'b1, "timeout_trap");
    setCtrl(3'b011, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd1, 7'd0, 1'b0, 1'b0, "timeout_pulse_drop");

    // Call and return.
    setCtrl(3'b010, 2'b00, 1'b0, 7'd7);
    applyStimulus(7'd7, 7'd0, 1'b0, 1'b0, "jump7");
    setCtrl(3'b110, 2'b00, 1'b0, 7'd30);
    applyStimulus(7'd30, 7'd8, 1'b0, 1'b0, "call30");
    setCtrl(3'b011, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd31, 7'd8, 1'b0, 1'b0, "inc_in_sub");
    setCtrl(3'b111, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd8, 7'd8, 1'b0, 1'b0, "return8");

    // Counter clears on a successful exit; a wait exiting on cycle 15 never traps.
    setCtrl(3'b101, 2'b00, 1'b0, 7'd3);
    for (int i = 0; i < 10; i++) applyStimulus(7'd8, 7'd8, 1'b0, 1'b0, "clr_hold");
    moc = 1'b1;
    applyStimulus(7'd3, 7'd8, 1'b0, 1'b0, "clr_exit");
    moc = 1'b0;
    for (int i = 0; i < 14; i++) applyStimulus(7'd3, 7'd8, 1'b0, 1'b0, "edge_hold");
    cr_state = 7'd4;
    moc = 1'b1;
    applyStimulus(7'd4, 7'd8, 1'b0, 1'b0, "edge_exit");
    moc = 1'b0;

    // Remaining condition sources.
    setCtrl(3'b100, 2'b10, 1'b0, 7'd15);
    cond_in = 1'b1;
    applyStimulus(7'd15, 7'd8, 1'b0, 1'b0, "cond_in_taken");
    setCtrl(3'b100, 2'b11, 1'b1, 7'd15);
    applyStimulus(7'd16, 7'd8, 1'b0, 1'b0, "const_inverted");
    setCtrl(3'b100, 2'b11, 1'b0, 7'd2);
    applyStimulus(7'd2, 7'd8, 1'b0, 1'b0, "const_taken");
    cond_in = 1'b0;

    // Illegal next states.
    setCtrl(3'b010, 2'b00, 1'b0, 7'd45);
    applyStimulus(7'd0, 7'd8, 1'b1, 1'b0, "illegal_jump");
    setCtrl(3'b011, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd1, 7'd8, 1'b0, 1'b0, "illegal_pulse_drop");
    setCtrl(3'b110, 2'b00, 1'b0, 7'd100);
    applyStimulus(7'd0, 7'd8, 1'b1, 1'b0, "illegal_call");
    setCtrl(3'b111, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd8, 7'd8, 1'b0, 1'b0, "return_after_bad_call");

    // Boundary at MAX_STATE, explicit fetch, and a call whose return is illegal.
    setCtrl(3'b010, 2'b00, 1'b0, 7'd38);
    applyStimulus(7'd38, 7'd8, 1'b0, 1'b0, "jump_max");
    setCtrl(3'b001, 2'b00, 1'b0, 7'd38);
    applyStimulus(7'd0, 7'd8, 1'b0, 1'b0, "fetch");
    setCtrl(3'b010, 2'b00, 1'b0, 7'd38);
    applyStimulus(7'd38, 7'd8, 1'b0, 1'b0, "jump_max2");
    setCtrl(3'b011, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd0, 7'd8, 1'b1, 1'b0, "inc_past_max");
    setCtrl(3'b010, 2'b00, 1'b0, 7'd38);
    applyStimulus(7'd38, 7'd8, 1'b0, 1'b0, "jump_max3");
    setCtrl(3'b110, 2'b00, 1'b0, 7'd10);
    applyStimulus(7'd10, 7'd39, 1'b0, 1'b0, "call_bad_ret");
    setCtrl(3'b111, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd0, 7'd39, 1'b1, 1'b0, "return_illegal");
    setCtrl(3'b011, 2'b00, 1'b0, 7'd0);
    applyStimulus(7'd1, 7'd39, 1'b0, 1'b0, "inc_after_illegal");

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vec_count++;
      fail_count++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state logic and state register for the microprogrammed MIPS control unit.
- Sits directly upstream of the microstore. It drives the 7-bit current-state address that selects the 45-bit control word.
- Its inputs are the next-state fields of that same control word, the instruction-dispatch state from the opcode encoder, and the datapath conditions (memory-operation-complete, ALU zero, branch condition).
- It sequences one microinstruction per clock. It supports dispatch, jump, increment, conditional branch, conditional wait with timeout, and a single-level micro-call/return.

Parameters:
- STATE_W, 7: width of state addresses.
- MAX_STATE, 38: highest legal state. Any computed next state above this is illegal.
- FETCH_STATE, 0: state entered on reset, on ns_sel=001, and on an illegal next state.
- TRAP_STATE, 0: state entered on a wait timeout.
- TIMEOUT, 15: number of consecutive held wait cycles before a trap.
- CNT_W, 4: width of the wait counter. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- ns_sel, input, 3: next-state select field from the control word.
- cond_sel, input, 2: condition select. 00 = moc, 01 = zero, 10 = cond_in, 11 = constant 1.
- cond_inv, input, 1: inverts the selected condition.
- cr_state, input, STATE_W: target-state field from the control word.
- enc_state, input, STATE_W: dispatch state from the opcode encoder.
- moc, input, 1: memory operation complete.
- zero, input, 1: ALU zero flag.
- cond_in, input, 1: branch condition-tester output.
- currentState, output, STATE_W: registered state address to the microstore.
- ret_state, output, STATE_W: micro-return register, exposed for visibility.
- illegal_pulse, output, 1: one-cycle pulse on entry to FETCH_STATE after an illegal next state.
- timeout_pulse, output, 1: one-cycle pulse on entry to TRAP_STATE after a wait timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - currentState=FETCH_STATE, ret_state=0, wait_cnt=0.
  - illegal_pulse=0, timeout_pulse=0.
  - Reset asserted mid-wait or mid-call clears everything immediately. No clock is needed.
- Condition: c = selected condition XOR cond_inv.
- Increment: inc = currentState+1, truncated to STATE_W. Wrap-around at 2^STATE_W is not special-cased; it falls under the illegal-state rule if above MAX_STATE.
- Next-state candidate nxt, combinational from ns_sel:
  - 000: enc_state (dispatch).
  - 001: FETCH_STATE.
  - 010: cr_state (jump).
  - 011: inc.
  - 100: c ? cr_state : inc.
  - 101: c ? cr_state : currentState (wait/hold).
  - 110: cr_state (call). ret_state <= inc on the same edge.
  - 111: ret_state (return).
- Priority at each rising edge, highest first:
  - Timeout: ns_sel=101, c=0 and wait_cnt==TIMEOUT-1 → currentState<=TRAP_STATE, timeout_pulse<=1, wait_cnt<=0.
  - Illegal: nxt > MAX_STATE → currentState<=FETCH_STATE, illegal_pulse<=1. ret_state is not updated, even on a call.
  - Otherwise: currentState<=nxt.
  - Both pulses deassert on the following cycle unless the event repeats.
- Wait counter:
  - Increments while ns_sel=101 and c=0.
  - Clears on any other cycle, including a successful wait exit (c=1).
  - A wait that succeeds on cycle N≤TIMEOUT-1 never traps.
- Call/return:
  - Call nesting is single-level. A second call overwrites ret_state.
  - A return with no prior call goes to 0, the reset value.
  - A call whose target is legal but whose return address inc is illegal still updates ret_state. The illegal-state check applies only when the return executes.
- Latency:
  - Control fields are combinational from the microstore output of currentState, so a new state is taken every cycle.
  - Datapath conditions are sampled at the same edge that updates currentState.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset release, then ns_sel=011 for 3 cycles → currentState 0,1,2,3. Asserting reset=0 mid-sequence → currentState=0 immediately, without a clock edge.
- Dispatch: ns_sel=000, enc_state=12 → next currentState=12. Then ns_sel=100, cond_sel=01, zero=1, cr_state=20 → 20. With zero=0 → inc instead.
- Wait with success:
  - Setup: ns_sel=101, cond_sel=00, cr_state=9, moc=0 for 5 cycles, then moc=1.
  - Required: currentState stays put for 5 cycles, then goes to 9. timeout_pulse stays 0 throughout.
- Wait timeout: same setup with moc held at 0 → after 15 cycles currentState=TRAP_STATE(0), timeout_pulse high for exactly 1 cycle, wait_cnt=0.
- Call/return: at state 7, ns_sel=110, cr_state=30 → currentState=30 and ret_state=8. Later ns_sel=111 → currentState=8.
- Illegal state: ns_sel=010, cr_state=45 → currentState=0 and illegal_pulse=1 for 1 cycle. A call with cr_state=100 → currentState=0 and ret_state unchanged.
